// File: rtl/map_loader.sv
// map_loader: streams a serial bit map into a WIDTH x HEIGHT grid, row-major, counting 1-cells.
// Define MAP_LOADER_VERIFY_EN to add a read-back pass that compares the grid's 1-count to ones_count.
module map_loader #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int ADDR_W = 4,
  parameter int ADDR_H = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  output logic                     mem_wr,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr_x,
  output logic [ADDR_H-1:0]        mem_addr_y,
  output logic                     mem_data_in,
  input  logic                     mem_data_out,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W+ADDR_H:0]   ones_count,
  output logic                     err,
  output logic [1:0]               state_dbg
);

  localparam int CW = ADDR_W + ADDR_H + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] x, x_nxt;
  logic [ADDR_H-1:0] y, y_nxt;
  logic              x_last, y_last;

  // Explicit wrap at WIDTH-1 / HEIGHT-1 so non-power-of-two grids scan correctly.
  assign x_last = (x == ADDR_W'(WIDTH - 1));
  assign y_last = (y == ADDR_H'(HEIGHT - 1));
  assign x_nxt  = x_last ? '0 : x + 1'b1;
  assign y_nxt  = x_last ? (y_last ? '0 : y + 1'b1) : y;

  // Handshake: a beat transfers on a rising edge where bit_valid & bit_ready;
  // bit_ready is high for the whole LOAD state, so the write strobe is just LOAD & bit_valid.
  assign bit_ready   = (state == LOAD);
  assign busy        = (state == LOAD) || (state == VERIFY);
  assign mem_wr      = (state == LOAD) && bit_valid;
  assign mem_data_in = bit_in;
  assign mem_addr_x  = x;
  assign mem_addr_y  = y;
  assign state_dbg   = state;

`ifdef MAP_LOADER_VERIFY_EN
  logic [CW-1:0] vsum;
  logic          err_q;
  assign mem_rd = (state == VERIFY);
  assign err    = err_q;
`else
  logic unused_rd;
  assign unused_rd = mem_data_out;
  assign mem_rd    = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      ones_count <= '0;
      done       <= 1'b0;
`ifdef MAP_LOADER_VERIFY_EN
      vsum       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            x          <= '0;
            y          <= '0;
            ones_count <= '0;
            done       <= 1'b0;
`ifdef MAP_LOADER_VERIFY_EN
            err_q      <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (bit_valid) begin
            ones_count <= ones_count + CW'(bit_in);
            x          <= x_nxt;
            y          <= y_nxt;
            if (x_last && y_last) begin
`ifdef MAP_LOADER_VERIFY_EN
              state <= VERIFY;
              vsum  <= '0;
`else
              state <= DONE;
              done  <= 1'b1;
`endif
            end
          end
        end
`ifdef MAP_LOADER_VERIFY_EN
        VERIFY: begin
          x <= x_nxt;
          y <= y_nxt;
          // The last cell's read data is folded in directly rather than through vsum.
          if (x_last && y_last) begin
            err_q <= ((vsum + CW'(mem_data_out)) != ones_count);
            state <= DONE;
            done  <= 1'b1;
          end else begin
            vsum <= vsum + CW'(mem_data_out);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
